// File: rtl/spectrum_peak_finder.sv
// Per-frame peak search over a spectrum stream: reports the strongest bin
// at or above MIN_BIN (lowest index wins ties) once every N_BINS samples.
module spectrum_peak_finder #(
    parameter int N_BINS  = 256,
    parameter int MIN_BIN = 1,
    localparam int BW     = $clog2(N_BINS)
) (
    input  logic                clk,
    input  logic                arstn,
    input  logic                i_vld,
    input  logic                i_sof,
    input  logic signed [31:0]  i_mag,
    input  logic signed [31:0]  i_phase,
    output logic                o_vld,
    output logic [BW-1:0]       o_bin,
    output logic signed [31:0]  o_mag,
    output logic signed [31:0]  o_phase,
    output logic                o_err
);

    typedef enum logic {IDLE, ACCUM} state_t;

    localparam logic [BW-1:0] LAST_BIN = BW'(N_BINS - 1);
    localparam logic [BW-1:0] MIN_IDX  = BW'(MIN_BIN);

    state_t             state_q, state_d;
    logic [BW-1:0]      cnt_q, cnt_d;
    logic               have_best_q, have_best_d;
    logic [BW-1:0]      best_bin_q, best_bin_d;
    logic signed [31:0] best_mag_q, best_mag_d;
    logic signed [31:0] best_phase_q, best_phase_d;

    logic               start;
    logic               accept;
    logic               last;
    logic               abort;
    logic [BW-1:0]      idx;

    always_comb begin
        state_d      = state_q;
        cnt_d        = cnt_q;
        have_best_d  = have_best_q;
        best_bin_d   = best_bin_q;
        best_mag_d   = best_mag_q;
        best_phase_d = best_phase_q;
        start        = 1'b0;
        accept       = 1'b0;
        last         = 1'b0;
        abort        = 1'b0;
        idx          = '0;

        if (i_vld) begin
            unique case (state_q)
                IDLE: begin
                    if (i_sof) begin
                        start  = 1'b1;
                        accept = 1'b1;
                    end
                end
                ACCUM: begin
                    accept = 1'b1;
                    if (i_sof) begin
                        start = 1'b1;
                        abort = 1'b1;
                    end else begin
                        idx  = cnt_q;
                        last = (cnt_q == LAST_BIN);
                    end
                end
                default: ;
            endcase
        end

        if (start) begin
            state_d     = ACCUM;
            cnt_d       = BW'(1);
            have_best_d = 1'b0;
        end else if (accept) begin
            cnt_d = cnt_q + BW'(1);
        end

        // have_best_d is already cleared on a frame start, so bin 0 can load when MIN_BIN is 0
        if (accept && (idx >= MIN_IDX) && (!have_best_d || (i_mag > best_mag_q))) begin
            have_best_d  = 1'b1;
            best_bin_d   = idx;
            best_mag_d   = i_mag;
            best_phase_d = i_phase;
        end

        if (last) begin
            state_d     = IDLE;
            cnt_d       = '0;
            have_best_d = 1'b0;
        end
    end

    always_ff @(posedge clk or negedge arstn) begin
        if (!arstn) begin
            state_q      <= IDLE;
            cnt_q        <= '0;
            have_best_q  <= 1'b0;
            best_bin_q   <= '0;
            best_mag_q   <= '0;
            best_phase_q <= '0;
        end else begin
            state_q      <= state_d;
            cnt_q        <= cnt_d;
            have_best_q  <= have_best_d;
            best_bin_q   <= best_bin_d;
            best_mag_q   <= best_mag_d;
            best_phase_q <= best_phase_d;
        end
    end

    always_ff @(posedge clk or negedge arstn) begin
        if (!arstn) begin
            o_vld   <= 1'b0;
            o_err   <= 1'b0;
            o_bin   <= '0;
            o_mag   <= '0;
            o_phase <= '0;
        end else begin
            o_vld <= last;
            o_err <= abort;
            if (last) begin
                o_bin   <= best_bin_d;
                o_mag   <= best_mag_d;
                o_phase <= best_phase_d;
            end
        end
    end

endmodule

// File: tb/tb_spectrum_peak_finder.sv
// Directed and randomized bench for spectrum_peak_finder (N_BINS=8, MIN_BIN=1)
// against a frame-level reference model built from queues.
module tb_spectrum_peak_finder;

    localparam int N_BINS  = 8;
    localparam int MIN_BIN = 1;
    localparam int BW      = $clog2(N_BINS);

    logic                clk = 1'b0;
    logic                arstn = 1'b0;
    logic                i_vld = 1'b0;
    logic                i_sof = 1'b0;
    logic signed [31:0]  i_mag = '0;
    logic signed [31:0]  i_phase = '0;
    logic                o_vld;
    logic [BW-1:0]       o_bin;
    logic signed [31:0]  o_mag;
    logic signed [31:0]  o_phase;
    logic                o_err;

    int checks = 0;
    int errors = 0;

    // Reference model state
    logic signed [31:0] fm[$];
    logic signed [31:0] fp[$];
    bit                 in_frame = 1'b0;
    logic               exp_vld = 1'b0;
    logic               exp_err = 1'b0;
    logic [BW-1:0]      exp_bin = '0;
    logic signed [31:0] exp_mag = '0;
    logic signed [31:0] exp_phase = '0;
    int                 vld_pulses = 0;
    int                 err_pulses = 0;

    logic signed [31:0] mags[N_BINS];
    logic signed [31:0] phs[N_BINS];

    spectrum_peak_finder #(.N_BINS(N_BINS), .MIN_BIN(MIN_BIN)) dut (
        .clk    (clk),
        .arstn  (arstn),
        .i_vld  (i_vld),
        .i_sof  (i_sof),
        .i_mag  (i_mag),
        .i_phase(i_phase),
        .o_vld  (o_vld),
        .o_bin  (o_bin),
        .o_mag  (o_mag),
        .o_phase(o_phase),
        .o_err  (o_err)
    );

    always #5 clk = ~clk;

    task automatic model_reset();
        fm.delete();
        fp.delete();
        in_frame  = 1'b0;
        exp_vld   = 1'b0;
        exp_err   = 1'b0;
        exp_bin   = '0;
        exp_mag   = '0;
        exp_phase = '0;
    endtask

    task automatic model_edge(input logic v, input logic s,
                              input logic signed [31:0] m, input logic signed [31:0] p);
        int best;
        exp_vld = 1'b0;
        exp_err = 1'b0;
        if (v && s) begin
            if (in_frame) exp_err = 1'b1;
            fm.delete();
            fp.delete();
            fm.push_back(m);
            fp.push_back(p);
            in_frame = 1'b1;
        end else if (v && in_frame) begin
            fm.push_back(m);
            fp.push_back(p);
            if (fm.size() == N_BINS) begin
                best = -1;
                for (int i = MIN_BIN; i < N_BINS; i++)
                    if (best < 0 || fm[i] > fm[best]) best = i;
                exp_vld   = 1'b1;
                exp_bin   = BW'(best);
                exp_mag   = fm[best];
                exp_phase = fp[best];
                in_frame  = 1'b0;
            end
        end
        if (exp_vld) vld_pulses++;
        if (exp_err) err_pulses++;
    endtask

    task automatic check_outputs(input string tag);
        checks++;
        assert (o_vld === exp_vld) else begin
            errors++;
            $error("FAIL %s o_vld observed=%0b expected=%0b", tag, o_vld, exp_vld);
        end
        checks++;
        assert (o_err === exp_err) else begin
            errors++;
            $error("FAIL %s o_err observed=%0b expected=%0b", tag, o_err, exp_err);
        end
        checks++;
        assert (o_bin === exp_bin) else begin
            errors++;
            $error("FAIL %s o_bin observed=%0d expected=%0d", tag, o_bin, exp_bin);
        end
        checks++;
        assert (o_mag === exp_mag) else begin
            errors++;
            $error("FAIL %s o_mag observed=%0d expected=%0d", tag, o_mag, exp_mag);
        end
        checks++;
        assert (o_phase === exp_phase) else begin
            errors++;
            $error("FAIL %s o_phase observed=%0d expected=%0d", tag, o_phase, exp_phase);
        end
    endtask

    task automatic step(input string tag, input logic v, input logic s,
                        input logic signed [31:0] m, input logic signed [31:0] p);
        i_vld   = v;
        i_sof   = s;
        i_mag   = m;
        i_phase = p;
        @(posedge clk);
        #1;
        if (arstn) model_edge(v, s, m, p);
        check_outputs(tag);
    endtask

    task automatic idle(input string tag, input int n);
        for (int k = 0; k < n; k++)
            step(tag, 1'b0, 1'($urandom_range(0, 1)), $urandom, $urandom);
    endtask

    task automatic send_frame(input string tag, input int gap);
        for (int b = 0; b < N_BINS; b++) begin
            step(tag, 1'b1, (b == 0), mags[b], phs[b]);
            if (gap > 0 && b < N_BINS - 1) idle(tag, gap);
        end
    endtask

    task automatic load_frame(input logic signed [31:0] m0, input logic signed [31:0] m1,
                              input logic signed [31:0] m2, input logic signed [31:0] m3,
                              input logic signed [31:0] m4, input logic signed [31:0] m5,
                              input logic signed [31:0] m6, input logic signed [31:0] m7);
        mags[0] = m0; mags[1] = m1; mags[2] = m2; mags[3] = m3;
        mags[4] = m4; mags[5] = m5; mags[6] = m6; mags[7] = m7;
        for (int b = 0; b < N_BINS; b++) phs[b] = 100 * b;
    endtask

    task automatic expect_pulses(input string tag, input int vld_n, input int err_n);
        checks++;
        assert (vld_pulses === vld_n) else begin
            errors++;
            $error("FAIL %s vld_pulses observed=%0d expected=%0d", tag, vld_pulses, vld_n);
        end
        checks++;
        assert (err_pulses === err_n) else begin
            errors++;
            $error("FAIL %s err_pulses observed=%0d expected=%0d", tag, err_pulses, err_n);
        end
    endtask

    task automatic pulse_reset(input string tag);
        #3;
        arstn = 1'b0;
        #1;
        model_reset();
        check_outputs({tag, "_async"});
        step({tag, "_held"}, i_vld, i_sof, i_mag, i_phase);
        @(negedge clk);
        arstn = 1'b1;
    endtask

    initial begin
        model_reset();
        #2;
        check_outputs("reset_init");
        @(negedge clk);
        arstn = 1'b1;
        idle("post_reset", 2);

        // DC bin excluded, tie at 70 keeps bin 3
        load_frame(900, 10, 20, 70, 30, 70, 5, 1);
        send_frame("contig", 0);
        checks++;
        assert (o_vld === 1'b1 && o_bin === 3'd3 && o_mag === 32'sd70 && o_phase === 32'sd300) else begin
            errors++;
            $error("FAIL contig_result observed=%0b/%0d/%0d/%0d expected=1/3/70/300",
                   o_vld, o_bin, o_mag, o_phase);
        end
        idle("contig_tail", 3);

        vld_pulses = 0; err_pulses = 0;
        send_frame("gaps", 3);
        idle("gaps_tail", 4);
        expect_pulses("gaps", 1, 0);

        // Abort after 5 samples, then a full frame peaking at bin 6
        vld_pulses = 0; err_pulses = 0;
        for (int b = 0; b < 5; b++) step("abort_part", 1'b1, (b == 0), 1000, b);
        load_frame(7, 1, 2, 3, 4, 5, 500, 6);
        send_frame("abort_full", 0);
        checks++;
        assert (o_bin === 3'd6 && o_mag === 32'sd500) else begin
            errors++;
            $error("FAIL abort_result observed=%0d/%0d expected=6/500", o_bin, o_mag);
        end
        idle("abort_tail", 2);
        expect_pulses("abort", 1, 1);

        // Sof landing on what would be bin 7
        vld_pulses = 0; err_pulses = 0;
        for (int b = 0; b < N_BINS - 1; b++) step("late_sof_part", 1'b1, (b == 0), 50, b);
        load_frame(0, 3, 3, 3, 3, 3, 3, 3);
        send_frame("late_sof_full", 0);
        idle("late_sof_tail", 2);
        expect_pulses("late_sof", 1, 1);

        // Back-to-back frames, then hold check
        vld_pulses = 0; err_pulses = 0;
        load_frame(0, 1, 90, 2, 3, 4, 5, 6);
        send_frame("b2b_a", 0);
        load_frame(0, 1, 2, 3, 4, 5, 6, 77);
        send_frame("b2b_b", 0);
        idle("b2b_hold", 5);
        expect_pulses("b2b", 2, 0);

        // Reset during bin 4, stray samples, then a clean frame
        vld_pulses = 0; err_pulses = 0;
        for (int b = 0; b < 4; b++) step("rst_part", 1'b1, (b == 0), 400, b);
        i_vld = 1'b1; i_sof = 1'b0; i_mag = 400; i_phase = 4;
        pulse_reset("rst_mid");
        for (int k = 0; k < 3; k++) step("rst_stray", 1'b1, 1'b0, 999, k);
        load_frame(0, 11, 12, 13, 40, 15, 16, 17);
        send_frame("rst_frame", 0);
        idle("rst_tail", 2);
        expect_pulses("rst", 1, 0);

        // Signed comparison
        load_frame(-20, -5, -3, -9, -20, -20, -20, -20);
        send_frame("neg", 0);
        checks++;
        assert (o_vld === 1'b1 && o_bin === 3'd2 && o_mag === -32'sd3) else begin
            errors++;
            $error("FAIL neg_result observed=%0b/%0d/%0d expected=1/2/-3", o_vld, o_bin, o_mag);
        end
        idle("neg_tail", 2);

        // Randomized frames with gaps, ties, negatives and early aborts
        for (int f = 0; f < 60; f++) begin
            int cut;
            int gap;
            for (int b = 0; b < N_BINS; b++) begin
                mags[b] = $signed($urandom_range(0, 40)) - 32'sd20;
                phs[b]  = $urandom;
            end
            cut = ($urandom_range(0, 5) == 0) ? $urandom_range(1, N_BINS - 1) : N_BINS;
            for (int b = 0; b < cut; b++) begin
                step("rand", 1'b1, (b == 0), mags[b], phs[b]);
                gap = ($urandom_range(0, 3) == 0) ? $urandom_range(1, 3) : 0;
                if (gap > 0) idle("rand_gap", gap);
            end
            if ($urandom_range(0, 9) == 0) step("rand_stray", 1'b1, 1'b0, $urandom, $urandom);
        end
        idle("rand_tail", 3);

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

    initial begin
        #200000;
        errors++;
        $display("FAIL timeout observed=running expected=finished");
        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $fatal(1, "timeout");
    end

endmodule

// File: doc/spectrum_peak_finder.md
SPECTRUM_PEAK_FINDER -- requirements
Module: spectrum_peak_finder

Interface
REQ-001 Parameter N_BINS, default 256; bins per frame, range 2..4096.
REQ-002 Parameter MIN_BIN, default 1; lowest bin eligible as peak (DC skip), range 0..N_BINS-1.
REQ-003 Parameter BW, derived as $clog2(N_BINS); bin index width.
REQ-004 clk  in  1  single clock, all logic on rising edge.
REQ-005 arstn  in  1  reset, asynchronous assert, active-low.
REQ-006 i_vld  in  1  input sample valid, one bin per valid cycle, no backpressure.
REQ-007 i_sof  in  1  start of frame; qualified by i_vld; marks bin 0.
REQ-008 i_mag  in  32  signed magnitude from the cartesian-to-polar stage.
REQ-009 i_phase  in  32  signed phase from the cartesian-to-polar stage.
REQ-010 o_vld  out  1  one-cycle pulse, frame result valid.
REQ-011 o_bin  out  BW  index of peak bin.
REQ-012 o_mag  out  32  signed magnitude of peak bin.
REQ-013 o_phase  out  32  signed phase of peak bin.
REQ-014 o_err  out  1  one-cycle pulse, frame aborted by early i_sof.

Function
REQ-015 FSM states: IDLE, ACCUM.
REQ-016 IDLE: i_vld&&i_sof accepts bin 0, sets bin counter to 1, moves to ACCUM.
REQ-017 IDLE: i_vld without i_sof is discarded, with no output effect.
REQ-018 ACCUM: each i_vld&&!i_sof accepts the next bin and increments the counter.
REQ-019 Candidate rule: bins with index < MIN_BIN are never candidates.
REQ-020 First candidate in a frame (index == MIN_BIN) loads best unconditionally; a have_best flag tracks this.
REQ-021 Later candidate replaces best only if i_mag > best_mag (signed, strict); ties keep the lowest index.
REQ-022 Accepting bin N_BINS-1 ends the frame; the next cycle o_vld=1 with o_bin/o_mag/o_phase including that bin; FSM returns to IDLE.
REQ-023 Latency: o_vld is 1 cycle after the last bin's accept edge; back-to-back frames (i_sof on the cycle after the last bin) are accepted with no gap.
REQ-024 ACCUM with i_vld&&i_sof: current frame is discarded, o_err=1 next cycle, o_vld stays 0, and the sample restarts a frame as bin 0 (counter=1, stay ACCUM).
REQ-025 i_sof on the cycle that would be bin N_BINS-1: abort rule REQ-024 takes priority, with no o_vld.
REQ-026 o_vld and o_err are never both 1 in the same cycle.
REQ-027 o_bin/o_mag/o_phase update only with o_vld and hold their values between pulses.
REQ-028 Idle cycles (i_vld=0) inside a frame are allowed without limit; counter and best hold.
REQ-029 i_sof with i_vld=0 is ignored.

Reset
REQ-030 arstn=0 asynchronously forces: IDLE, counter=0, have_best=0, o_vld=0, o_err=0, o_bin=0, o_mag=0, o_phase=0.
REQ-031 Reset mid-frame discards the partial frame; after release, only i_vld&&i_sof starts a frame.
REQ-032 Reset deassertion need not be synchronized inside the block; the integrator supplies a synchronous release.

Verification (N_BINS=8, MIN_BIN=1)
REQ-033 Frame mags 900,10,20,70,30,70,5,1 (phase=100*bin), contiguous -> o_vld 1 cycle after bin 7, o_bin=3, o_mag=70, o_phase=300 (DC excluded, tie keeps lower index).
REQ-034 Same frame with i_vld gaps of 3 cycles between bins -> identical result, single o_vld pulse.
REQ-035 Sof at bin 0, then 4 bins, then i_sof, then a full 8-bin frame with peak 500 at bin 6 -> one o_err pulse, then o_vld with o_bin=6, o_mag=500.
REQ-036 Two back-to-back frames (peaks at bins 2 and 7), no idle cycle -> two o_vld pulses 8 cycles apart with correct results; outputs hold between pulses.
REQ-037 arstn low during bin 4, then released, then 3 non-sof samples, then a full frame -> all outputs 0 during reset, non-sof samples ignored, one correct o_vld.
REQ-038 Negative magnitudes -5,-3,-9 in bins 1..3 and -20 in the rest -> o_bin=2, o_mag=-3 (signed compare).
